// File: rtl/riscv_pkg.sv
// Shared core definitions: RV32I load funct3 codes and the per-load metadata
// record carried through the data-memory read latency.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Thread-tag width baked into load_meta_t; load_unit's TID_WIDTH must match it.
  localparam int LOAD_TID_WIDTH = 4;

  typedef struct packed {
    logic                      valid;
    logic [2:0]                funct3;
    logic [1:0]                addr;
    logic [4:0]                rd;
    logic [LOAD_TID_WIDTH-1:0] tid;
  } load_meta_t;

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction with zero/sign extension.
// Misaligned LH/LHU/LW detection is compiled in with LOAD_MISALIGN_DETECT_EN.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
  end

  // Half-word lane uses addr[1] only; addr[0] is truncated away.
  assign lane_h = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    misaligned = 1'b0;
`ifdef LOAD_MISALIGN_DETECT_EN
    misaligned = ((funct3 == F3_LH || funct3 == F3_LHU) && addr[0]) ||
                 (funct3 == F3_LW && addr != 2'b00);
`endif
    data = '0;
    if (!misaligned) begin
      case (funct3)
        F3_LB:   data = {{24{lane_b[7]}}, lane_b};
        F3_LH:   data = {{16{lane_h[15]}}, lane_h};
        F3_LW:   data = word;
        F3_LBU:  data = {24'h0, lane_b};
        F3_LHU:  data = {16'h0, lane_h};
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_unit.sv
// Load writeback unit: tracks load metadata across MEM_LATENCY (1..4) cycles,
// aligns the returned word and registers a tagged result. Optional: LOAD_MISALIGN_DETECT_EN.
module load_unit
  import riscv_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int TID_WIDTH   = LOAD_TID_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr,
  input  logic [4:0]           i_rd,
  input  logic [TID_WIDTH-1:0] i_tid,
  input  logic [31:0]          i_mem_data,
  output logic                 o_valid,
  output logic [31:0]          o_data,
  output logic [4:0]           o_rd,
  output logic [TID_WIDTH-1:0] o_tid,
  output logic                 o_misaligned
);

  load_meta_t  stage [MEM_LATENCY];
  load_meta_t  issue;
  load_meta_t  last;
  logic [31:0] align_data;
  logic        align_mis;

  // Idle slots carry all-zero fields so the pipeline contents stay deterministic.
  always_comb begin
    issue = '0;
    if (i_load) begin
      issue.valid  = 1'b1;
      issue.funct3 = i_funct3;
      issue.addr   = i_addr;
      issue.rd     = i_rd;
      issue.tid    = i_tid;
    end
  end

  assign last = stage[MEM_LATENCY-1];

  load_align u_align (
    .funct3     (last.funct3),
    .addr       (last.addr),
    .word       (i_mem_data),
    .data       (align_data),
    .misaligned (align_mis)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= issue;
      for (int i = 1; i < MEM_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  // Result fields only update on a valid final stage, otherwise they hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_rd         <= '0;
      o_tid        <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_valid <= last.valid;
      if (last.valid) begin
        o_data       <= align_data;
        o_rd         <= last.rd;
        o_tid        <= last.tid;
        o_misaligned <= align_mis;
      end
    end
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-path counterpart of the core's store byte-lane unit: captures load metadata (funct3, addr[1:0], rd, thread id) at issue and tracks it through the data-memory read latency.
- When the memory word returns, it extracts the byte/half/word lane and zero- or sign-extends it.
- Delivers a registered, tagged writeback result to the register file stage.
- Accepts one load per cycle with no stalls, matching the barrel-threaded pipeline.

Parameters:
- MEM_LATENCY, 1, cycles from i_load to i_mem_data being valid (legal 1..4).
- TID_WIDTH, 4, width of the hardware-thread tag carried with each load.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- i_load  input  1  load issued this cycle (memory read launched same cycle).
- i_funct3  input  3  RV32I load funct3.
- i_addr  input  2  byte offset of effective address.
- i_rd  input  5  destination register.
- i_tid  input  TID_WIDTH  issuing thread.
- i_mem_data  input  32  aligned word from data memory, valid MEM_LATENCY cycles after i_load.
- o_valid  output  1  writeback result valid (one-cycle pulse per load).
- o_data  output  32  extended load result.
- o_rd  output  5  destination register of the result.
- o_tid  output  TID_WIDTH  thread of the result.
- o_misaligned  output  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all metadata stages cleared, o_valid=0, o_data=0, o_rd=0, o_tid=0, o_misaligned=0.
- Metadata pipeline: MEM_LATENCY-deep shift register of {valid, funct3, addr, rd, tid}. Stage 0 loads {i_load, inputs} every cycle. A stage with valid=0 carries don't-care fields, but the implementation zeroes them.
- Alignment stage: when the final metadata stage is valid, i_mem_data is sampled that cycle, and the result plus tags are registered. Total latency is i_load to o_valid = MEM_LATENCY+1 cycles.
- Throughput: one load per cycle, fully pipelined. Consecutive loads from different threads produce consecutive o_valid pulses in issue order.
- o_valid=0 cycles: o_data, o_rd, o_tid and o_misaligned hold their last values.
- Extraction, with byte b = i_mem_data[8*addr+7 -: 8] and half h = i_mem_data[16*addr[1]+15 -: 16]:
  - 000 LB: sign-extend b.
  - 001 LH: sign-extend h.
  - 010 LW: full word.
  - 100 LBU: zero-extend b.
  - 101 LHU: zero-extend h.
- Other funct3 values: o_valid still pulses with o_data=0 (illegal-instruction detection is the decoder's job).
- LH/LHU use addr[1] only for lane selection; addr[0] is ignored for the lane. LW ignores addr.
- i_load when i_funct3 is not a load: tracked like any load; the rule above applies.
- Reset asserted with loads in flight: all in-flight entries are discarded. No o_valid occurs after release for loads issued before reset.
- i_mem_data is ignored in any cycle whose final stage is invalid.

Optional Feature:
- Macro LOAD_MISALIGN_DETECT_EN.
- Defined:
  - o_misaligned=1, registered with o_valid, for LH/LHU with addr[0]=1 or LW with addr!=0.
  - In that case o_data=0, o_valid still pulses so the trap logic sees the tid/rd.
- Undefined: o_misaligned tied 0, and lane selection follows the truncation rules above.

Decomposition:
- Shared package riscv_pkg holds:
  - Load funct3 localparams: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - A packed struct load_meta_t {valid, funct3, addr, rd, tid} parameterised by TID_WIDTH via a package constant.
- One combinational sub-module, load_align (funct3, addr, word -> data, misaligned). It is reusable by any future MMIO load path.
- load_unit owns the metadata pipeline and output register.

Test Plan:
- Byte sign-extension: MEM_LATENCY=1, LB addr=2 rd=5 tid=3, i_mem_data=0x12_80_34_56 at cycle+1 -> at cycle+2 o_valid=1, o_data=0xFFFFFF80, o_rd=5, o_tid=3. Same with LBU -> 0x00000080.
- Half-word lanes: LH addr=2 with word 0x8001_7FFF -> 0xFFFF8001. LHU addr=0 -> 0x00007FFF.
- Back-to-back issue: MEM_LATENCY=2, four consecutive loads (LW, LB a=1, LHU a=2, LBU a=3) tids 0..3 on word 0xA1B2C3D4 -> o_valid high four consecutive cycles starting cycle+3:
  - 0xA1B2C3D4
  - 0xFFFFFFC3
  - 0x0000A1B2
  - 0x000000A1
- Reset mid-flight: issue LW, assert reset_n=0 the next cycle for one cycle -> all outputs 0 immediately (asynchronously). No o_valid for that load after release.
- Misalign/illegal:
  - With LOAD_MISALIGN_DETECT_EN, LW addr=1 -> o_valid=1, o_misaligned=1, o_data=0.
  - Without the macro -> o_misaligned=0, o_data=full word.
  - funct3=011 -> o_valid=1, o_data=0.
- Idle/hold: no i_load for 10 cycles while i_mem_data toggles randomly -> o_valid stays 0, and o_data holds its last value.
